// File: rtl/cp0_bus_port.sv
// cp0_bus_port: system control coprocessor register file and its read port
// onto the datapath bus. This block holds Status, Cause, EPC, BadVAddr and
// PRId, and optionally Random.
// The optional Random register (CP0 address 1) is built only when
// CP0_RANDOM_EN is defined. Without it, address 1 reads as zero.
module cp0_bus_port (
    input  logic        Phi1,
    input  logic        Reset_b,
    input  logic [31:0] Cp0BusIn_s2m,
    input  logic        MvToCop0_s2m,
    input  logic        MvFromCop0_s2m,
    input  logic [4:0]  Cp0RegAddr_s2m,
    input  logic        Stall_s1,
    input  logic        Exception_s1w,
    input  logic [4:0]  ExcCode,
    input  logic        ExcBD,
    input  logic [31:0] ExcPC,
    input  logic [31:0] ExcBadVA,
    input  logic        ExcBadVAValid,
    input  logic        Rfe_s1w,
    input  logic [5:0]  IntReq,
    output logic [31:0] Cp0BusOut_s2m,
    output logic        Cp0BusDrv_s2m,
    output logic        StatusKUc,
    output logic        StatusIEc
);

    localparam logic [4:0]  ADDR_RANDOM   = 5'd1;
    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [4:0]  ADDR_PRID     = 5'd15;

    localparam logic [31:0] STATUS_MASK   = 32'h1040_FF3F;
    localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
    localparam logic [31:0] PRID_VALUE    = 32'h0000_0230;

    logic [31:0] status_q;
    logic        cause_bd_q;
    logic [1:0]  cause_ip_sw_q;
    logic [4:0]  cause_exc_q;
    logic [5:0]  int_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] cause_rd;
    logic [31:0] random_rd;
    logic [31:0] rd_data;
    logic        mtc0_win;

    // An MTC0 only lands when neither an exception nor an RFE claims the cycle
    assign mtc0_win = MvToCop0_s2m && !Exception_s1w && !Rfe_s1w;

    assign cause_rd = {cause_bd_q, 15'b0, int_q, cause_ip_sw_q, 1'b0, cause_exc_q, 2'b00};

    assign StatusKUc = status_q[1];
    assign StatusIEc = status_q[0];

    // Status: exception pushes the KU/IE stack, RFE pops it, and MTC0 writes only the implemented bits
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            status_q <= STATUS_RESET;
        end else if (Exception_s1w) begin
            status_q[5:0] <= {status_q[3:0], 2'b00};
        end else if (Rfe_s1w) begin
            status_q[3:0] <= status_q[5:2];
        end else if (mtc0_win && Cp0RegAddr_s2m == ADDR_STATUS) begin
            status_q <= Cp0BusIn_s2m & STATUS_MASK;
        end
    end

    // Cause: the exception code and BD come from exception entry, and the software IP bits come from MTC0
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            cause_bd_q    <= 1'b0;
            cause_exc_q   <= '0;
            cause_ip_sw_q <= '0;
        end else if (Exception_s1w) begin
            cause_bd_q  <= ExcBD;
            cause_exc_q <= ExcCode;
        end else if (mtc0_win && Cp0RegAddr_s2m == ADDR_CAUSE) begin
            cause_ip_sw_q <= Cp0BusIn_s2m[9:8];
        end
    end

    // Hardware interrupt lines are level sensitive and sampled every cycle
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            int_q <= '0;
        end else begin
            int_q <= IntReq;
        end
    end

    // EPC and BadVAddr are loaded only on exception entry and are read-only to MTC0
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else if (Exception_s1w) begin
            epc_q <= ExcPC;
            if (ExcBadVAValid) begin
                badvaddr_q <= ExcBadVA;
            end
        end
    end

`ifdef CP0_RANDOM_EN
    logic [5:0] random_q;

    // Random counts down through 63..8 and skips stalled cycles
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            random_q <= 6'd63;
        end else if (!Stall_s1) begin
            random_q <= (random_q == 6'd8) ? 6'd63 : random_q - 6'd1;
        end
    end

    assign random_rd = {18'b0, random_q, 8'b0};
`else
    assign random_rd = '0;
`endif

    // Read mux uses the pre-update register values, so a write and a read in the same cycle return the old contents
    always_comb begin
        rd_data = '0;
        case (Cp0RegAddr_s2m)
            ADDR_RANDOM:   rd_data = random_rd;
            ADDR_BADVADDR: rd_data = badvaddr_q;
            ADDR_STATUS:   rd_data = status_q;
            ADDR_CAUSE:    rd_data = cause_rd;
            ADDR_EPC:      rd_data = epc_q;
            ADDR_PRID:     rd_data = PRID_VALUE;
            default:       rd_data = '0;
        endcase
    end

    // Read response register: one cycle of data and drive, held while stalled, and a request arriving during a hold is dropped
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            Cp0BusDrv_s2m <= 1'b0;
            Cp0BusOut_s2m <= '0;
        end else if (Cp0BusDrv_s2m && Stall_s1) begin
            Cp0BusDrv_s2m <= 1'b1;
        end else if (MvFromCop0_s2m) begin
            Cp0BusDrv_s2m <= 1'b1;
            Cp0BusOut_s2m <= rd_data;
        end else begin
            Cp0BusDrv_s2m <= 1'b0;
            Cp0BusOut_s2m <= '0;
        end
    end

endmodule

// File: tb/tb_cp0_bus_port.sv
// Directed bench for cp0_bus_port. Expected values are computed by hand from the register map and its masks.
// The Random checks follow CP0_RANDOM_EN in the same way as the design.
module tb_cp0_bus_port;

    logic        Phi1 = 1'b0;
    logic        Reset_b = 1'b1;
    logic [31:0] Cp0BusIn_s2m = '0;
    logic        MvToCop0_s2m = 1'b0;
    logic        MvFromCop0_s2m = 1'b0;
    logic [4:0]  Cp0RegAddr_s2m = '0;
    logic        Stall_s1 = 1'b0;
    logic        Exception_s1w = 1'b0;
    logic [4:0]  ExcCode = '0;
    logic        ExcBD = 1'b0;
    logic [31:0] ExcPC = '0;
    logic [31:0] ExcBadVA = '0;
    logic        ExcBadVAValid = 1'b0;
    logic        Rfe_s1w = 1'b0;
    logic [5:0]  IntReq = '0;
    logic [31:0] Cp0BusOut_s2m;
    logic        Cp0BusDrv_s2m;
    logic        StatusKUc;
    logic        StatusIEc;

    int vectors = 0;
    int miscompares = 0;

    cp0_bus_port dut (
        .Phi1           (Phi1),
        .Reset_b        (Reset_b),
        .Cp0BusIn_s2m   (Cp0BusIn_s2m),
        .MvToCop0_s2m   (MvToCop0_s2m),
        .MvFromCop0_s2m (MvFromCop0_s2m),
        .Cp0RegAddr_s2m (Cp0RegAddr_s2m),
        .Stall_s1       (Stall_s1),
        .Exception_s1w  (Exception_s1w),
        .ExcCode        (ExcCode),
        .ExcBD          (ExcBD),
        .ExcPC          (ExcPC),
        .ExcBadVA       (ExcBadVA),
        .ExcBadVAValid  (ExcBadVAValid),
        .Rfe_s1w        (Rfe_s1w),
        .IntReq         (IntReq),
        .Cp0BusOut_s2m  (Cp0BusOut_s2m),
        .Cp0BusDrv_s2m  (Cp0BusDrv_s2m),
        .StatusKUc      (StatusKUc),
        .StatusIEc      (StatusIEc)
    );

    always #5 Phi1 = ~Phi1;

    // Advance past the next rising edge and settle before sampling
    task automatic tick;
        @(posedge Phi1);
        #1;
    endtask

    // Issue a one-cycle read and capture the response visible in the following cycle
    task automatic issue_read(input logic [4:0] a, output logic [31:0] d, output logic v);
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = a;
        tick();
        d = Cp0BusOut_s2m;
        v = Cp0BusDrv_s2m;
        MvFromCop0_s2m = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        MvToCop0_s2m   = 1'b1;
        Cp0RegAddr_s2m = a;
        Cp0BusIn_s2m   = d;
        tick();
        MvToCop0_s2m   = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        Reset_b = 1'b0;
        #1;
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== 33'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got drv=%b data=%h, expected drv=0 data=00000000", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
        vectors++;
        if ({StatusKUc, StatusIEc} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mode: got KUc/IEc=%b%b, expected 00", StatusKUc, StatusIEc);
        end
        tick();
        Reset_b = 1'b1;
    endtask

    task automatic test_status_read;
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = 5'd12;
        #1;
        vectors++;
        if (Cp0BusDrv_s2m !== 1'b0) begin
            miscompares++;
            $display("FAIL read_latency_early: got drv=%b, expected 0", Cp0BusDrv_s2m);
        end
        tick();
        MvFromCop0_s2m = 1'b0;
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, 32'h0040_0000}) begin
            miscompares++;
            $display("FAIL read_status_reset: got drv=%b data=%h, expected drv=1 data=00400000", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
        tick();
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== 33'h0) begin
            miscompares++;
            $display("FAIL read_one_cycle: got drv=%b data=%h, expected drv=0 data=00000000", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
    endtask

    task automatic test_reset_values;
        logic [4:0]  addrs [6] = '{5'd13, 5'd14, 5'd8, 5'd15, 5'd3, 5'd31};
        logic [31:0] exps  [6] = '{32'h0, 32'h0, 32'h0, 32'h0000_0230, 32'h0, 32'h0};
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 6; i++) begin
            issue_read(addrs[i], d, v);
            vectors++;
            if ({v, d} !== {1'b1, exps[i]}) begin
                miscompares++;
                $display("FAIL reset_value reg%0d: got drv=%b data=%h, expected drv=1 data=%h", addrs[i], v, d, exps[i]);
            end
        end
        tick();
    endtask

    task automatic test_status_write;
        logic [31:0] d;
        logic        v;
        mtc0(5'd12, 32'hFFFF_FFFF);
        vectors++;
        if ({StatusKUc, StatusIEc} !== 2'b11) begin
            miscompares++;
            $display("FAIL status_mode_bits: got KUc/IEc=%b%b, expected 11", StatusKUc, StatusIEc);
        end
        issue_read(5'd12, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h1040_FF3F}) begin
            miscompares++;
            $display("FAIL status_mask: got drv=%b data=%h, expected drv=1 data=1040ff3f", v, d);
        end
        tick();
    endtask

    task automatic test_write_masks;
        logic [4:0]  addrs [6] = '{5'd13, 5'd13, 5'd14, 5'd8, 5'd15, 5'd20};
        logic [31:0] wdata [6] = '{32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] exps  [6] = '{32'h0000_0300, 32'h0, 32'h0, 32'h0, 32'h0000_0230, 32'h0};
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 6; i++) begin
            mtc0(addrs[i], wdata[i]);
            issue_read(addrs[i], d, v);
            vectors++;
            if ({v, d} !== {1'b1, exps[i]}) begin
                miscompares++;
                $display("FAIL write_mask reg%0d: got drv=%b data=%h, expected drv=1 data=%h", addrs[i], v, d, exps[i]);
            end
        end
        tick();
    endtask

    task automatic test_same_cycle_rw;
        logic [31:0] d;
        logic        v;
        MvToCop0_s2m   = 1'b1;
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = 5'd12;
        Cp0BusIn_s2m   = 32'h0;
        tick();
        MvToCop0_s2m   = 1'b0;
        MvFromCop0_s2m = 1'b0;
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, 32'h1040_FF3F}) begin
            miscompares++;
            $display("FAIL rw_old_value: got drv=%b data=%h, expected drv=1 data=1040ff3f", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
        issue_read(5'd12, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL rw_new_value: got drv=%b data=%h, expected drv=1 data=00000000", v, d);
        end
        tick();
    endtask

    task automatic test_priority;
        logic [4:0]  addrs [4] = '{5'd12, 5'd14, 5'd13, 5'd8};
        logic [31:0] exp1  [4] = '{32'h0040_0004, 32'h8000_0180, 32'h8000_0020, 32'h0};
        logic [31:0] exp2  [4] = '{32'h0000_0034, 32'h0000_0100, 32'h0000_0010, 32'hDEAD_BEEF};
        logic [31:0] d;
        logic        v;
        mtc0(5'd12, 32'h0040_0001);
        // Exception and MTC0 to Status in the same cycle; the exception wins
        Exception_s1w  = 1'b1;
        ExcCode        = 5'd8;
        ExcBD          = 1'b1;
        ExcPC          = 32'h8000_0180;
        ExcBadVA       = 32'h1111_2222;
        ExcBadVAValid  = 1'b0;
        MvToCop0_s2m   = 1'b1;
        Cp0RegAddr_s2m = 5'd12;
        Cp0BusIn_s2m   = 32'hFFFF_FFFF;
        tick();
        Exception_s1w  = 1'b0;
        MvToCop0_s2m   = 1'b0;
        vectors++;
        if ({StatusKUc, StatusIEc} !== 2'b00) begin
            miscompares++;
            $display("FAIL exc_mode_bits: got KUc/IEc=%b%b, expected 00", StatusKUc, StatusIEc);
        end
        for (int i = 0; i < 4; i++) begin
            issue_read(addrs[i], d, v);
            vectors++;
            if ({v, d} !== {1'b1, exp1[i]}) begin
                miscompares++;
                $display("FAIL exc_entry reg%0d: got drv=%b data=%h, expected drv=1 data=%h", addrs[i], v, d, exp1[i]);
            end
        end
        // RFE and MTC0 together; RFE wins
        Rfe_s1w        = 1'b1;
        MvToCop0_s2m   = 1'b1;
        Cp0RegAddr_s2m = 5'd12;
        Cp0BusIn_s2m   = 32'hFFFF_FFFF;
        tick();
        Rfe_s1w        = 1'b0;
        MvToCop0_s2m   = 1'b0;
        issue_read(5'd12, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0040_0001}) begin
            miscompares++;
            $display("FAIL rfe_pop: got drv=%b data=%h, expected drv=1 data=00400001", v, d);
        end
        // RFE keeps the old KU/IE pair in [5:4]
        mtc0(5'd12, 32'h0000_0035);
        Rfe_s1w = 1'b1;
        tick();
        Rfe_s1w = 1'b0;
        issue_read(5'd12, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0000_003D}) begin
            miscompares++;
            $display("FAIL rfe_keep_old: got drv=%b data=%h, expected drv=1 data=0000003d", v, d);
        end
        // Exception with a valid BadVA
        Exception_s1w = 1'b1;
        ExcCode       = 5'd4;
        ExcBD         = 1'b0;
        ExcPC         = 32'h0000_0100;
        ExcBadVA      = 32'hDEAD_BEEF;
        ExcBadVAValid = 1'b1;
        tick();
        Exception_s1w = 1'b0;
        ExcBadVAValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_read(addrs[i], d, v);
            vectors++;
            if ({v, d} !== {1'b1, exp2[i]}) begin
                miscompares++;
                $display("FAIL exc_badva reg%0d: got drv=%b data=%h, expected drv=1 data=%h", addrs[i], v, d, exp2[i]);
            end
        end
        tick();
    endtask

    task automatic test_stall;
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = 5'd14;
        tick();
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, 32'h0000_0100}) begin
            miscompares++;
            $display("FAIL stall_first: got drv=%b data=%h, expected drv=1 data=00000100", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
        // A second request to Status during the stall must be ignored
        Stall_s1       = 1'b1;
        Cp0RegAddr_s2m = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, 32'h0000_0100}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got drv=%b data=%h, expected drv=1 data=00000100", i, Cp0BusDrv_s2m, Cp0BusOut_s2m);
            end
        end
        Stall_s1       = 1'b0;
        MvFromCop0_s2m = 1'b0;
        tick();
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== 33'h0) begin
            miscompares++;
            $display("FAIL stall_release: got drv=%b data=%h, expected drv=0 data=00000000", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
    endtask

    task automatic test_reset_during_hold;
        logic [31:0] d;
        logic        v;
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = 5'd14;
        tick();
        MvFromCop0_s2m = 1'b0;
        Stall_s1       = 1'b1;
        vectors++;
        if (Cp0BusDrv_s2m !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_before_reset: got drv=%b, expected 1", Cp0BusDrv_s2m);
        end
        #2;
        Reset_b = 1'b0;
        #1;
        vectors++;
        if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== 33'h0) begin
            miscompares++;
            $display("FAIL reset_drops_hold: got drv=%b data=%h, expected drv=0 data=00000000", Cp0BusDrv_s2m, Cp0BusOut_s2m);
        end
        @(negedge Phi1);
        Reset_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== 33'h0) begin
                miscompares++;
                $display("FAIL no_resp_after_reset%0d: got drv=%b data=%h, expected drv=0 data=00000000", i, Cp0BusDrv_s2m, Cp0BusOut_s2m);
            end
        end
        Stall_s1 = 1'b0;
        issue_read(5'd12, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0040_0000}) begin
            miscompares++;
            $display("FAIL status_after_reset: got drv=%b data=%h, expected drv=1 data=00400000", v, d);
        end
        tick();
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_rd;
        IntReq  = 6'b100001;
        Reset_b = 1'b0;
        tick();
        Reset_b        = 1'b1;
        MvFromCop0_s2m = 1'b1;
        Cp0RegAddr_s2m = 5'd1;
`ifdef CP0_RANDOM_EN
        for (int k = 0; k < 57; k++) begin
            tick();
            exp_rd = (k < 56) ? (32'(63 - k) << 8) : 32'h0000_3F00;
            vectors++;
            if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, exp_rd}) begin
                miscompares++;
                $display("FAIL random_step%0d: got drv=%b data=%h, expected drv=1 data=%h", k, Cp0BusDrv_s2m, Cp0BusOut_s2m, exp_rd);
            end
        end
`else
        exp_rd = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({Cp0BusDrv_s2m, Cp0BusOut_s2m} !== {1'b1, exp_rd}) begin
                miscompares++;
                $display("FAIL random_absent%0d: got drv=%b data=%h, expected drv=1 data=%h", k, Cp0BusDrv_s2m, Cp0BusOut_s2m, exp_rd);
            end
        end
`endif
        MvFromCop0_s2m = 1'b0;
        issue_read(5'd13, d, v);
        vectors++;
        if ({v, d} !== {1'b1, 32'h0000_8400}) begin
            miscompares++;
            $display("FAIL cause_intreq: got drv=%b data=%h, expected drv=1 data=00008400", v, d);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_reset_values();
        test_status_write();
        test_write_masks();
        test_same_cycle_rw();
        test_priority();
        test_stall();
        test_reset_during_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_bus_port.md
CP0_BUS_PORT -- requirements
Module: cp0_bus_port

Interface
REQ-001 The block SHALL have a single clock Phi1; all state SHALL change on the rising edge of Phi1.
REQ-002 Reset_b  in  1  SHALL be the asynchronous, active-low reset.
REQ-003 Cp0BusIn_s2m  in  32  SHALL carry MTC0 data staged from the datapath.
REQ-004 MvToCop0_s2m  in  1  SHALL mark a CP0 register write in the current cycle.
REQ-005 MvFromCop0_s2m  in  1  SHALL mark a CP0 register read request in the current cycle.
REQ-006 Cp0RegAddr_s2m  in  5  SHALL give the CP0 register number for the read or write.
REQ-007 Stall_s1  in  1  SHALL freeze the read output and the Random counter.
REQ-008 Exception_s1w  in  1  SHALL mark exception entry, with these qualifiers:
- ExcCode  in  5  exception code.
- ExcBD  in  1  exception taken in a branch delay slot.
- ExcPC  in  32  restart PC.
- ExcBadVA  in  32  faulting address.
- ExcBadVAValid  in  1  load BadVAddr on this exception.
REQ-009 Rfe_s1w  in  1  SHALL mark a return-from-exception.
REQ-010 IntReq  in  6  SHALL carry the hardware interrupt lines (level sensitive).
REQ-011 Cp0BusOut_s2m  out  32  SHALL carry the read data toward the datapath MemBus driver.
REQ-012 Cp0BusDrv_s2m  out  1  SHALL qualify Cp0BusOut_s2m and enable the datapath tri-state.
REQ-013 StatusKUc, StatusIEc  out  1 each  SHALL carry the current mode bits.

Function
REQ-014 The register map SHALL be:
- BadVAddr = 8.
- Status = 12.
- Cause = 13.
- EPC = 14.
- PRId = 15, constant 0x00000230, read-only.
- Random = 1.
- All other addresses SHALL read 0 and ignore writes.
REQ-015 A write SHALL update the addressed register at the Phi1 edge ending the MvToCop0_s2m cycle; the new value SHALL be readable in the next cycle.
REQ-016 Write masks SHALL be:
- Status: bits 28, 22, 15:8 and 5:0 writable; all other bits read 0.
- Cause: only bits 9:8 (software IP) writable.
- EPC and BadVAddr: read-only to MTC0.
REQ-017 A read SHALL present registered data on Cp0BusOut_s2m with Cp0BusDrv_s2m=1 exactly one cycle after MvFromCop0_s2m, and SHALL hold both for one cycle only.
REQ-018 Outside a read response, Cp0BusDrv_s2m SHALL be 0 and Cp0BusOut_s2m SHALL be 0.
REQ-019 While Stall_s1=1, a pending read response SHALL hold its data and Cp0BusDrv_s2m until the first unstalled cycle; a new read request SHALL be ignored while a response is held.
REQ-020 Cause SHALL be composed as follows:
- Bit 31 = BD.
- Bits 15:10 = IntReq, sampled every cycle.
- Bits 9:8 = software IP.
- Bits 6:2 = ExcCode.
- All other bits 0.
REQ-021 On Exception_s1w, the block SHALL perform all of the following:
- Status[5:0] <= {Status[3:0], 2'b00}.
- EPC <= ExcPC.
- Cause.ExcCode and Cause.BD loaded from ExcCode and ExcBD.
- BadVAddr <= ExcBadVA only if ExcBadVAValid=1.
REQ-022 On Rfe_s1w, Status[3:0] SHALL be loaded with Status[5:2], and Status[5:4] SHALL be unchanged.
REQ-023 Priority in one cycle SHALL be Exception > Rfe > MTC0; the losing update SHALL be discarded completely.
REQ-024 A simultaneous read and write to the same register SHALL return the old value.
REQ-025 MvToCop0_s2m and MvFromCop0_s2m asserted together SHALL perform both the write and the read.

Reset
REQ-026 On Reset_b=0, immediately and independent of Phi1, the block SHALL set:
- Status = 0x00400000 (BEV=1).
- Cause, EPC and BadVAddr = 0.
- Random = 63.
- Cp0BusOut_s2m = 0, Cp0BusDrv_s2m = 0.
- StatusKUc = 0, StatusIEc = 0.
REQ-027 Assertion of reset during a held read response SHALL drop the response, and no response SHALL appear after reset release.

Configuration
REQ-028 With CP0_RANDOM_EN defined, Random SHALL work as follows:
- Random[13:8] decrements by 1 every unstalled cycle.
- It wraps from 8 to 63.
- It reads with all other bits 0.
- Writes to it SHALL be ignored.
REQ-029 Without CP0_RANDOM_EN, address 1 SHALL read 0 and no Random counter SHALL exist.

Verification
REQ-030 Reset, then read reg 12 -> Cp0BusOut_s2m=0x00400000 with Cp0BusDrv_s2m=1 exactly one cycle later, then Drv=0.
REQ-031 MTC0 reg 12 with 0xFFFFFFFF, then read -> 0x1040FF3F; StatusIEc=1, StatusKUc=1.
REQ-032 Status[5:0]=0x01, Exception (ExcCode=8, ExcBD=1, ExcPC=0x80000180) in the same cycle as MTC0 reg 12 -> results:
- Status[5:0]=0x04 (MTC0 discarded).
- EPC=0x80000180.
- Cause=0x80000020.
- Rfe then gives Status[5:0]=0x01.
REQ-033 Read request with Stall_s1 held 3 cycles -> Drv and data held 3 cycles, released on the first unstalled cycle; a second request during the stall is ignored.
REQ-034 CP0_RANDOM_EN defined, 56 unstalled cycles after reset -> Random reads 63, 62, …, 8, 63; with IntReq=6'b100001, Cause[15:10]=6'b100001.
